// File: rtl/partial_sum_accumulator_if.sv
// Valid/ready bundle between the 4-input adder stage, the partial-sum
// accumulator and the downstream result consumer.
interface partial_sum_accumulator_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_ovf;
  logic              busy;

  // master: adder stage plus result consumer; slave: the accumulator
  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/partial_sum_accumulator.sv
// Accumulates NUM_CHUNKS unsigned partial sums into one neuron pre-activation.
// Optional macro PSUM_ACC_SATURATE_EN clamps out_sum on overflow instead of wrapping.
module partial_sum_accumulator #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  partial_sum_accumulator_if.slave  bus
);

  localparam int unsigned      CNT_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [ACC_W-1:0] DATA_MAX = ACC_W'({DATA_W{1'b1}});

  if ((NUM_CHUNKS < 1) || (NUM_CHUNKS > 256)) begin : g_chunks_chk
    $error("partial_sum_accumulator: NUM_CHUNKS must be in 1..256");
  end
  if (ACC_W < DATA_W + $clog2(NUM_CHUNKS)) begin : g_acc_w_chk
    $error("partial_sum_accumulator: ACC_W too narrow for DATA_W and NUM_CHUNKS");
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_sum;
  logic              r_out_ovf;
  logic              r_busy;

  logic              w_accept;
  logic              w_last;
  logic [ACC_W-1:0]  w_acc_final;
  logic              w_ovf;
  logic [DATA_W-1:0] w_sum_final;

  // in_sum only reaches state through w_accept, so X on an idle bus is harmless
  assign w_accept    = bus.in_valid & r_in_ready & (r_state == ST_ACCUM);
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_acc_final = r_acc + ACC_W'(bus.in_sum);
  assign w_ovf       = (w_acc_final > DATA_MAX);

`ifdef PSUM_ACC_SATURATE_EN
  assign w_sum_final = w_ovf ? {DATA_W{1'b1}} : w_acc_final[DATA_W-1:0];
`else
  assign w_sum_final = w_acc_final[DATA_W-1:0];
`endif

  // Control FSM; every output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc  <= w_acc_final;
            r_busy <= 1'b1;
            if (w_last) begin
              r_cnt       <= '0;
              r_out_sum   <= w_sum_final;
              r_out_ovf   <= w_ovf;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Directed bench for partial_sum_accumulator: default build (NUM_CHUNKS=4)
// plus a NUM_CHUNKS=1 instance sharing clock and reset.
module tb_partial_sum_accumulator;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  partial_sum_accumulator_if #(.DATA_W(16)) u_if ();
  partial_sum_accumulator_if #(.DATA_W(16)) u_if1 ();

  partial_sum_accumulator #(.DATA_W(16), .ACC_W(24), .NUM_CHUNKS(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  partial_sum_accumulator #(.DATA_W(16), .ACC_W(16), .NUM_CHUNKS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] v);
    u_if.in_valid = 1'b1;
    u_if.in_sum   = v;
    step();
  endtask

  task automatic idle();
    u_if.in_valid = 1'b0;
    u_if.in_sum   = 16'hxxxx;
    step();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] s,
                           input logic o, input logic rdy);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'(v));
    check({tag, "_sum"},   32'(u_if.out_sum),   32'(s));
    check({tag, "_ovf"},   32'(u_if.out_ovf),   32'(o));
    check({tag, "_ready"}, 32'(u_if.in_ready),  32'(rdy));
  endtask

  logic [15:0] exp_ovf_sum;

  initial begin
    n_vec  = 0;
    n_miss = 0;
`ifdef PSUM_ACC_SATURATE_EN
    exp_ovf_sum = 16'hFFFF;
`else
    exp_ovf_sum = 16'h0000;
`endif
    rst_n           = 1'b0;
    u_if.in_valid   = 1'b0;
    u_if.in_sum     = 16'h0000;
    u_if.out_ready  = 1'b1;
    u_if1.in_valid  = 1'b0;
    u_if1.in_sum    = 16'h0000;
    u_if1.out_ready = 1'b1;

    // reset values, held across clock edges
    #1;
    check_out("rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    check("rst_busy", 32'(u_if.busy), 32'h0);
    #22;
    check("rst_hold_ready", 32'(u_if.in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_pre", 32'(u_if.in_ready), 32'h0);
    step();
    check("rel_ready", 32'(u_if.in_ready), 32'h1);
    check("rel1_ready", 32'(u_if1.in_ready), 32'h1);

    // 1: basic accumulation
    beat(16'h0010);
    beat(16'h0020);
    beat(16'h0030);
    check_out("t1_mid", 1'b0, 16'h0000, 1'b0, 1'b1);
    check("t1_mid_busy", 32'(u_if.busy), 32'h1);
    beat(16'h0040);
    check_out("t1_res", 1'b1, 16'h00A0, 1'b0, 1'b0);
    check("t1_res_busy", 32'(u_if.busy), 32'h1);
    idle();
    check_out("t1_done", 1'b0, 16'h00A0, 1'b0, 1'b1);
    check("t1_done_busy", 32'(u_if.busy), 32'h0);

    // 2: overflow
    beat(16'hFFFF);
    beat(16'h0001);
    beat(16'h0000);
    beat(16'h0000);
    check_out("t2_res", 1'b1, exp_ovf_sum, 1'b1, 1'b0);
    idle();
    check("t2_done_valid", 32'(u_if.out_valid), 32'h0);

    // 3: output backpressure; input offered during HOLD must not be consumed
    u_if.out_ready = 1'b0;
    beat(16'h0100);
    beat(16'h0200);
    beat(16'h0300);
    beat(16'h0400);
    check_out("t3_res", 1'b1, 16'h0A00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      u_if.in_valid = 1'b1;
      u_if.in_sum   = 16'hFFFF;
      step();
      check_out("t3_stall", 1'b1, 16'h0A00, 1'b0, 1'b0);
    end
    u_if.out_ready = 1'b1;
    step();
    check_out("t3_release", 1'b0, 16'h0A00, 1'b0, 1'b1);
    check("t3_release_busy", 32'(u_if.busy), 32'h0);
    beat(16'h0001);
    beat(16'h0001);
    beat(16'h0001);
    beat(16'h0001);
    check_out("t3_fresh", 1'b1, 16'h0004, 1'b0, 1'b0);
    idle();

    // 4: input gaps with X on the idle bus
    beat(16'h0001);
    check("t4_busy_a", 32'(u_if.busy), 32'h1);
    idle();
    idle();
    check("t4_busy_b", 32'(u_if.busy), 32'h1);
    beat(16'h0002);
    idle();
    check("t4_busy_c", 32'(u_if.busy), 32'h1);
    check("t4_valid_c", 32'(u_if.out_valid), 32'h0);
    beat(16'h0003);
    beat(16'h0004);
    check_out("t4_res", 1'b1, 16'h000A, 1'b0, 1'b0);
    check("t4_res_busy", 32'(u_if.busy), 32'h1);
    idle();
    check("t4_done_busy", 32'(u_if.busy), 32'h0);

    // 5: asynchronous reset mid-accumulation
    beat(16'h0010);
    beat(16'h0020);
    u_if.in_valid = 1'b0;
    check("t5_pre_busy", 32'(u_if.busy), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("t5_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
    check("t5_rst_busy", 32'(u_if.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5_rel_ready", 32'(u_if.in_ready), 32'h1);
    beat(16'h0001);
    beat(16'h0001);
    beat(16'h0001);
    beat(16'h0001);
    check_out("t5_res", 1'b1, 16'h0004, 1'b0, 1'b0);
    idle();

    // 6: NUM_CHUNKS=1 instance, back-to-back offers show the HOLD bubble
    u_if1.in_valid = 1'b1;
    u_if1.in_sum   = 16'h1234;
    step();
    check("t6_a_valid", 32'(u_if1.out_valid), 32'h1);
    check("t6_a_sum",   32'(u_if1.out_sum),   32'h1234);
    check("t6_a_ovf",   32'(u_if1.out_ovf),   32'h0);
    check("t6_a_ready", 32'(u_if1.in_ready),  32'h0);
    u_if1.in_sum = 16'h5678;
    step();
    check("t6_bub_valid", 32'(u_if1.out_valid), 32'h0);
    check("t6_bub_ready", 32'(u_if1.in_ready),  32'h1);
    step();
    check("t6_b_valid", 32'(u_if1.out_valid), 32'h1);
    check("t6_b_sum",   32'(u_if1.out_sum),   32'h5678);
    check("t6_b_ovf",   32'(u_if1.out_ovf),   32'h0);
    u_if1.in_valid = 1'b0;
    step();
    check("t6_done_valid", 32'(u_if1.out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/partial_sum_accumulator.md
Name: partial_sum_accumulator

Overview:
- Downstream consumer of the 4-input unsigned adder stage in the neuron datapath.
- Accepts one 16-bit partial sum per handshake and accumulates NUM_CHUNKS consecutive partial sums into a single neuron pre-activation value.
- Presents the result, with an overflow flag, on a valid/ready output port.
- Lets wide dot products, longer than 4 taps, reuse the same 4-input adder across several cycles.

Parameters:
- DATA_W, 16: width of incoming partial sum and of out_sum.
- ACC_W, 24: internal accumulator width. Must satisfy ACC_W >= DATA_W + clog2(NUM_CHUNKS); elaboration error otherwise.
- NUM_CHUNKS, 4: partial sums per neuron result. Legal range 1..256.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_sum carries a valid partial sum.
- in_ready  output  1  block can accept a partial sum this cycle.
- in_sum  input  DATA_W  unsigned partial sum from the adder stage.
- out_valid  output  1  out_sum/out_ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  DATA_W  unsigned accumulated result (see Optional Feature).
- out_ovf  output  1  accumulated value exceeded 2^DATA_W-1.
- busy  output  1  at least one partial sum accumulated, result not yet delivered.

Behaviour:
- Reset (rst_n low, async assert, sync-deassert expected upstream):
  - state=ACCUM, acc=0, cnt=0.
  - in_ready=0 during reset; 1 the first cycle after release.
  - out_valid=0, out_sum=0, out_ovf=0, busy=0.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Beat accepted when in_valid & in_ready at a rising edge: acc <= acc + zero-extended in_sum.
  - Non-final beat (cnt != NUM_CHUNKS-1): cnt <= cnt+1, stay in ACCUM.
  - Final beat (cnt == NUM_CHUNKS-1): register the result into out_sum/out_ovf using acc + in_sum (includes the final beat), cnt <= 0, go to HOLD.
  - in_valid=0: no change.
- HOLD:
  - out_valid=1, in_ready=0. out_sum and out_ovf remain stable until the handshake completes.
  - out_valid & out_ready: acc <= 0, go to ACCUM. out_valid falls the next cycle.
  - out_ready=0: remain in HOLD indefinitely; no input consumed.
- Latency and throughput:
  - Result valid the cycle after the final beat is accepted.
  - Minimum NUM_CHUNKS+1 cycles per result (one bubble cycle in HOLD).
- NUM_CHUNKS=1: every accepted beat goes directly to HOLD; out_sum=in_sum, out_ovf=0.
- out_ovf = 1 iff the full ACC_W sum > 2^DATA_W-1. Computed from the full final sum, not sticky across results.
- Arithmetic:
  - Unsigned only.
  - The accumulator cannot wrap, by the parameter constraint.
- busy = (state==HOLD) | (cnt!=0).
- Reset mid-operation: partial accumulation is discarded and any pending result is lost. No output handshake occurs for the lost result.
- in_sum is ignored whenever in_valid=0 or in_ready=0. X on in_sum while in_valid=0 must not propagate.

Optional Feature:
- Macro: PSUM_ACC_SATURATE_EN.
- Defined: out_sum = out_ovf ? {DATA_W{1'b1}} : acc_final[DATA_W-1:0] (clamp to 0xFFFF at default width).
- Undefined: out_sum = acc_final[DATA_W-1:0] (truncating wrap).
- out_ovf behaves identically in both builds.

Test Plan:
1. Basic accumulation. Defaults, out_ready=1; feed 0x0010, 0x0020, 0x0030, 0x0040 back-to-back → one cycle after the 4th beat, out_valid=1, out_sum=0x00A0, out_ovf=0. in_ready=0 for exactly one cycle.
2. Overflow. Feed 0xFFFF, 0x0001, 0x0000, 0x0000 → out_ovf=1. out_sum=0xFFFF with PSUM_ACC_SATURATE_EN, 0x0000 without.
3. Output backpressure. out_ready=0 for 5 cycles after the result → out_valid, out_sum and out_ovf stable and in_ready=0 throughout. Raising out_ready for 1 cycle → out_valid falls next cycle, in_ready=1, next result starts from acc=0.
4. Input gaps. in_valid toggled 1,0,0,1,0,1,1 with values 1,X,X,2,X,3,4 → out_sum=0x000A, busy=1 from the first beat until the output handshake.
5. Reset mid-operation. After 2 beats (acc=0x0030), pulse rst_n low asynchronously between edges → all outputs 0 immediately. The subsequent 4 beats of 0x0001 give out_sum=0x0004.
6. NUM_CHUNKS=1 build. Beats 0x1234, 0x5678 with out_ready=1 → two results, 0x1234 then 0x5678, each one cycle after its beat, with a bubble between them.
